// File: rtl/iob_ila_capture.sv
// iob_ila_capture: ILA capture engine with pre-trigger window, decimation, trigger qualification and oldest-first readback
module iob_ila_capture #(
  parameter int SIGNAL_W  = 32,
  parameter int BUFFER_W  = 10,
  parameter int TRIGGER_W = 4,
  parameter int DEC_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SIGNAL_W-1:0]  signal,
  input  logic [TRIGGER_W-1:0] trigger,
  input  logic                 sample_en,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [TRIGGER_W-1:0] trigger_mask,
  input  logic [TRIGGER_W-1:0] trigger_negate,
  input  logic [TRIGGER_W-1:0] trigger_type,
  input  logic                 reduce_type,
  input  logic [BUFFER_W-1:0]  pre_samples,
  input  logic [DEC_W-1:0]     decimation,
  input  logic [BUFFER_W-1:0]  rd_index,
  output logic [SIGNAL_W-1:0]  rd_value,
  output logic [2:0]           state,
  output logic                 triggered,
  output logic                 done,
  output logic [BUFFER_W:0]    n_samples,
  output logic [BUFFER_W-1:0]  trigger_pos
);
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
  state_t state_q, state_d;
  logic [BUFFER_W-1:0] wr_ptr_q, wr_ptr_d, trig_pos_q, trig_pos_d, pre_lat_q, pre_lat_d;
  logic [BUFFER_W-1:0] pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d, post_len, rd_addr;
  logic [BUFFER_W:0] n_q, n_d;
  logic [DEC_W-1:0] dec_lat_q, dec_lat_d, dec_cnt_q, dec_cnt_d;
  logic [TRIGGER_W-1:0] t, hit, t_prev_q, t_prev_d;
  logic triggered_q, triggered_d, done_q, done_d, tick, fire, capturing, we;
  logic [SIGNAL_W-1:0] rd_value_q;
  logic [SIGNAL_W-1:0] mem [2**BUFFER_W];
  assign tick = sample_en && dec_cnt_q == '0;
  assign t = trigger ^ trigger_negate;
  assign hit = t & ~(trigger_type & t_prev_q);
  assign fire = |trigger_mask && (reduce_type ? &(hit | ~trigger_mask) : |(hit & trigger_mask));
  assign post_len = ~pre_lat_q;
  assign capturing = state_q inside {PRE, WAIT, POST};
  // A triggered capture is anchored on the trigger sample; otherwise on the newest n_samples writes.
  assign rd_addr = triggered_q ? trig_pos_q - pre_lat_q + rd_index : wr_ptr_q - n_q[BUFFER_W-1:0] + rd_index;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    n_d = n_q;
    trig_pos_d = trig_pos_q;
    triggered_d = triggered_q;
    done_d = done_q;
    pre_lat_d = pre_lat_q;
    dec_lat_d = dec_lat_q;
    pre_cnt_d = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    dec_cnt_d = dec_cnt_q;
    t_prev_d = tick ? t : t_prev_q;
    we = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d = 1'b0;
    end else if (arm && !abort && !capturing) begin
      pre_lat_d = pre_samples;
      dec_lat_d = decimation;
      wr_ptr_d = '0;
      n_d = '0;
      triggered_d = 1'b0;
      done_d = 1'b0;
      pre_cnt_d = '0;
      post_cnt_d = '0;
      state_d = pre_samples == '0 ? WAIT : PRE;
    end else if (capturing && sample_en) begin
      dec_cnt_d = dec_cnt_q == dec_lat_q ? '0 : dec_cnt_q + 1'b1;
      if (tick) begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        n_d = n_q[BUFFER_W] ? n_q : n_q + 1'b1;
        if (state_q == PRE) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          state_d = pre_cnt_d == pre_lat_q ? WAIT : PRE;
        end else if (state_q == WAIT && fire) begin
          trig_pos_d = wr_ptr_q;
          triggered_d = 1'b1;
          done_d = post_len == '0;
          state_d = post_len == '0 ? DONE : POST;
        end else if (state_q == POST) begin
          post_cnt_d = post_cnt_q + 1'b1;
          done_d = post_cnt_d == post_len;
          state_d = post_cnt_d == post_len ? DONE : POST;
        end
      end
    end
    dec_cnt_d = state_d inside {PRE, WAIT, POST} ? dec_cnt_d : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      n_q <= '0;
      trig_pos_q <= '0;
      triggered_q <= 1'b0;
      done_q <= 1'b0;
      pre_lat_q <= '0;
      dec_lat_q <= '0;
      pre_cnt_q <= '0;
      post_cnt_q <= '0;
      dec_cnt_q <= '0;
      t_prev_q <= '0;
      rd_value_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      n_q <= n_d;
      trig_pos_q <= trig_pos_d;
      triggered_q <= triggered_d;
      done_q <= done_d;
      pre_lat_q <= pre_lat_d;
      dec_lat_q <= dec_lat_d;
      pre_cnt_q <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      t_prev_q <= t_prev_d;
      rd_value_q <= mem[rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr_q] <= signal;
  end
  assign rd_value = rd_value_q;
  assign state = state_q;
  assign triggered = triggered_q;
  assign done = done_q;
  assign n_samples = n_q;
  assign trigger_pos = trig_pos_q;
endmodule

// File: tb/tb_iob_ila_capture.sv
// tb_iob_ila_capture: random and directed capture runs checked each cycle against a write-count based model
module tb_iob_ila_capture;
  localparam int D = 16;
  logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0, arm = 1'b0, abort = 1'b0, reduce_type = 1'b0;
  logic [31:0] signal = '0, rd_value;
  logic [3:0] trigger = '0, trigger_mask = '0, trigger_negate = '0, trigger_type = '0;
  logic [3:0] pre_samples = '0, rd_index = '0, trigger_pos;
  logic [7:0] decimation = '0;
  logic [2:0] state;
  logic triggered, done;
  logic [4:0] n_samples;
  int checks = 0, failures = 0;

  iob_ila_capture #(.SIGNAL_W(32), .BUFFER_W(4), .TRIGGER_W(4), .DEC_W(8)) dut (
    .clk(clk), .rst(rst), .signal(signal), .trigger(trigger), .sample_en(sample_en),
    .arm(arm), .abort(abort), .trigger_mask(trigger_mask), .trigger_negate(trigger_negate),
    .trigger_type(trigger_type), .reduce_type(reduce_type), .pre_samples(pre_samples),
    .decimation(decimation), .rd_index(rd_index), .rd_value(rd_value), .state(state),
    .triggered(triggered), .done(done), .n_samples(n_samples), .trigger_pos(trigger_pos));

  always #5 clk = ~clk;

  // Model: a capture is described by how many samples were written since arm and which write was the trigger.
  bit m_active, m_done, m_trig, exp_ok;
  int m_wcount, m_n, m_trig_wno, m_tpos, m_pre, m_dec, m_qual;
  logic [3:0] m_tprev;
  logic [31:0] ram_m [D];
  bit known_m [D];
  logic [31:0] exp_rd;

  function automatic int phase_m();
    if (!m_active) return m_done ? 4 : 0;
    if (m_wcount < m_pre) return 1;
    if (!m_trig) return 2;
    return 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] tv, hv;
    bit tk, fr;
    int ne, nh, ph, addr;
    tk = sample_en && (!m_active || m_qual % (m_dec + 1) == 0);
    tv = trigger ^ trigger_negate;
    ne = 0;
    nh = 0;
    for (int i = 0; i < 4; i++) begin
      hv[i] = trigger_type[i] ? (tv[i] && !m_tprev[i]) : tv[i];
      if (trigger_mask[i]) begin
        ne++;
        if (hv[i]) nh++;
      end
    end
    fr = ne > 0 && (reduce_type ? nh == ne : nh > 0);
    addr = m_trig ? (m_trig_wno - m_pre + rd_index) % D : (m_wcount - m_n + rd_index) % D;
    exp_rd = ram_m[addr];
    exp_ok = known_m[addr];
    if (rst) begin
      m_active = 0; m_done = 0; m_trig = 0; m_wcount = 0; m_n = 0; m_tpos = 0;
      m_pre = 0; m_dec = 0; m_qual = 0; m_tprev = '0; exp_rd = '0; exp_ok = 1;
    end else begin
      if (abort && (m_active || m_done)) begin
        m_active = 0;
        m_done = 0;
      end else if (arm && !abort && !m_active) begin
        m_pre = pre_samples; m_dec = decimation; m_wcount = 0; m_n = 0;
        m_trig = 0; m_done = 0; m_qual = 0; m_active = 1;
      end else if (m_active && sample_en) begin
        if (tk) begin
          ph = phase_m();
          ram_m[m_wcount % D] = signal;
          known_m[m_wcount % D] = 1;
          m_wcount++;
          if (m_n < D) m_n++;
          if (ph == 2 && fr) begin
            m_trig = 1;
            m_trig_wno = m_wcount - 1;
            m_tpos = (m_wcount - 1) % D;
          end
          if (m_trig && m_wcount - 1 - m_trig_wno == D - 1 - m_pre) begin
            m_active = 0;
            m_done = 1;
          end
        end
        m_qual++;
      end
      if (tk) m_tprev = tv;
    end
  end

  always @(negedge clk) begin
    chk("state", 64'(state), 64'(phase_m()));
    chk("triggered", 64'(triggered), 64'(m_trig));
    chk("done", 64'(done), 64'(m_done));
    chk("n_samples", 64'(n_samples), 64'(m_n));
    chk("trigger_pos", 64'(trigger_pos), 64'(m_tpos));
    if (exp_ok) chk("rd_value", 64'(rd_value), 64'(exp_rd));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("lit_reset_state", 64'(state), 64'd0);
    chk("lit_reset_rd", 64'(rd_value), 64'd0);
    trigger_mask = 4'd1; pre_samples = 4'd5; sample_en = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    chk("lit_pre_state", 64'(state), 64'd1);
    for (int v = 0; v <= 30; v++) begin
      signal = v; trigger = (v == 20) ? 4'd1 : 4'd0;
      step();
      if (v == 4) chk("lit_wait_after5", 64'(state), 64'd2);
      if (v == 19) chk("lit_not_trig", 64'(triggered), 64'd0);
      if (v == 20) chk("lit_trig", 64'(triggered), 64'd1);
      if (v == 29) chk("lit_not_done", 64'(done), 64'd0);
    end
    trigger = '0;
    chk("lit_done", 64'(done), 64'd1);
    chk("lit_n16", 64'(n_samples), 64'd16);
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i);
      step();
      chk("lit_readback", 64'(rd_value), 64'(15 + i));
    end
    rd_index = '0;
    pre_samples = 4'd15; arm = 1'b1; step(); arm = 1'b0;
    for (int v = 0; v <= 20; v++) begin
      signal = v; trigger = (v == 20) ? 4'd1 : 4'd0;
      step();
    end
    trigger = '0;
    chk("lit_pre15_done", 64'(done), 64'd1);
    rd_index = 4'd15; step();
    chk("lit_pre15_rd", 64'(rd_value), 64'd20);
    pre_samples = 4'd0; rd_index = '0; arm = 1'b1; step(); arm = 1'b0;
    chk("lit_pre0_wait", 64'(state), 64'd2);
    for (int v = 0; v <= 3; v++) begin
      signal = 100 + v; trigger = (v == 3) ? 4'd1 : 4'd0;
      step();
    end
    trigger = '0;
    for (int k = 0; k < 40 && !done; k++) step();
    chk("lit_pre0_done", 64'(done), 64'd1);
    step();
    chk("lit_pre0_rd0", 64'(rd_value), 64'd103);
    pre_samples = 4'd3; arm = 1'b1; step(); arm = 1'b0;
    for (int v = 0; v < 7; v++) begin
      signal = 200 + v;
      step();
    end
    sample_en = 1'b0; abort = 1'b1; step(); abort = 1'b0;
    chk("lit_abort_state", 64'(state), 64'd0);
    chk("lit_abort_n", 64'(n_samples), 64'd7);
    chk("lit_abort_trig", 64'(triggered), 64'd0);
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    chk("lit_arm_abort", 64'(state), 64'd0);
    sample_en = 1'b1; trigger_type = 4'd1; trigger = 4'd1; pre_samples = 4'd0;
    step();
    arm = 1'b1; step(); arm = 1'b0;
    repeat (10) step();
    chk("lit_edge_held", 64'(triggered), 64'd0);
    trigger = 4'd0; step();
    trigger = 4'd1; step();
    chk("lit_edge_rise", 64'(triggered), 64'd1);
    abort = 1'b1; step(); abort = 1'b0;
    trigger_type = '0; trigger_mask = 4'd3; reduce_type = 1'b1; trigger = '0;
    arm = 1'b1; step(); arm = 1'b0;
    trigger = 4'd1; step();
    trigger = 4'd2; step();
    chk("lit_and_partial", 64'(triggered), 64'd0);
    trigger = 4'd3; step();
    chk("lit_and_both", 64'(triggered), 64'd1);
    chk("lit_post", 64'(state), 64'd3);
    rst = 1'b1; trigger = '0; step(); rst = 1'b0;
    chk("lit_rst_state", 64'(state), 64'd0);
    chk("lit_rst_n", 64'(n_samples), 64'd0);
    chk("lit_rst_tpos", 64'(trigger_pos), 64'd0);
    chk("lit_rst_rd", 64'(rd_value), 64'd0);
    for (int c = 0; c < 60; c++) begin
      trigger_mask = 4'($urandom); trigger_negate = 4'($urandom);
      trigger_type = 4'($urandom); reduce_type = 1'($urandom);
      pre_samples = 4'($urandom); decimation = 8'($urandom_range(0, 2));
      arm = 1'b1; step(); arm = 1'b0;
      for (int k = 0; k < 100; k++) begin
        sample_en = ($urandom % 4) != 0;
        if ($urandom % 4 == 0) trigger = 4'($urandom);
        signal = $urandom;
        rd_index = 4'($urandom);
        arm = ($urandom % 50) == 0;
        abort = ($urandom % 120) == 0;
        rst = ($urandom % 400) == 0;
        step();
      end
      arm = 1'b0; abort = 1'b0; rst = 1'b0;
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
